// File: rtl/rv_multicycle_sequencer.sv
// Multi-cycle main-state sequencer for an RV32I datapath sharing one memory port.
// Optional retired-instruction counter is built when RETIRE_CNT_EN is defined.
module rv_multicycle_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    input  logic        stall,
    input  logic        trap_clr,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_en,
    output logic        pc_en,
    output logic        pc_sel,
    output logic        reg_we,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    localparam int unsigned TO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
    localparam bit          WDOG_EN = (MEM_TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DECODE = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM = 3'd3,
        S_WB = 3'd4,
        S_TRAP = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
    } cls_e;

    state_e             state_q, state_d;
    cls_e               cls_q, cls_d, opc_cls_c;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         fc_q, fc_d;
    logic               wait_expired_c;

    // Opcode class lookup; anything unlisted is illegal.
    always_comb begin
        opc_cls_c = C_NONE;
        unique case (opcode)
            7'b0110011: opc_cls_c = C_R;
            7'b0010011: opc_cls_c = C_I;
            7'b0000011: opc_cls_c = C_LOAD;
            7'b0100011: opc_cls_c = C_STORE;
            7'b1100011: opc_cls_c = C_BRANCH;
            7'b1101111: opc_cls_c = C_JAL;
            7'b1100111: opc_cls_c = C_JALR;
            7'b0110111: opc_cls_c = C_LUI;
            7'b0010111: opc_cls_c = C_AUIPC;
            default:    opc_cls_c = C_NONE;
        endcase
    end

    assign wait_expired_c = WDOG_EN && (cnt_q == CNT_W'(TO_LAST));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cls_q   <= C_NONE;
            cnt_q   <= '0;
            fc_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            fc_q    <= fc_d;
        end
    end

    // Next state; the wait counter is zero unless a request stays pending in place.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = '0;
        fc_d    = fc_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expired_c) begin
                    state_d = S_TRAP;
                    fc_d    = 2'b10;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (!stall) begin
                    if (opc_cls_c == C_NONE) begin
                        state_d = S_TRAP;
                        fc_d    = 2'b01;
                    end else begin
                        cls_d   = opc_cls_c;
                        state_d = S_EXECUTE;
                    end
                end
            end
            S_EXECUTE: begin
                if (!stall) begin
                    if (cls_q == C_LOAD || cls_q == C_STORE) begin
                        state_d = S_MEM;
                    end else if (cls_q == C_BRANCH) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
                end else if (wait_expired_c) begin
                    state_d = S_TRAP;
                    fc_d    = 2'b11;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                if (!stall) begin
                    state_d = S_FETCH;
                end
            end
            S_TRAP: begin
                if (trap_clr) begin
                    state_d = S_FETCH;
                    fc_d    = 2'b00;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Phase enables and memory handshake; everything is held low during reset.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        pc_sel     = 1'b0;
        reg_we     = 1'b0;
        fault      = 1'b0;
        fault_code = 2'b00;
        state      = 3'd0;
        if (rst_n) begin
            state      = state_q;
            fault_code = fc_q;
            unique case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_en   = mem_ready;
                end
                S_EXECUTE: begin
                    if (!stall && cls_q == C_BRANCH) begin
                        pc_en  = 1'b1;
                        pc_sel = branch_taken;
                    end
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (cls_q == C_STORE);
                    pc_en    = mem_ready && (cls_q == C_STORE);
                end
                S_WB: begin
                    if (!stall) begin
                        reg_we = 1'b1;
                        pc_en  = 1'b1;
                        pc_sel = (cls_q == C_JAL) || (cls_q == C_JALR);
                    end
                end
                S_TRAP: fault = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef RETIRE_CNT_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_q <= 32'h0;
        end else if (pc_en) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = rst_n ? instret_q : 32'h0;
`else
    assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_rv_multicycle_sequencer.sv
// Randomized bench for rv_multicycle_sequencer: per-instruction phase model builds the expected trace.
module tb_rv_multicycle_sequencer;

    localparam int unsigned TO = 4;

    localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LOAD = 3, K_STORE = 4,
                   K_BR = 5, K_JAL = 6, K_JALR = 7, K_LUI = 8, K_AUIPC = 9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        branch_taken, mem_ready, stall, trap_clr;
    logic        mem_req, mem_we, addr_sel, ir_en, pc_en, pc_sel, reg_we, fault;
    logic [1:0]  fault_code;
    logic [2:0]  state;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_instret = 32'h0;

    always #5 clk = ~clk;

    rv_multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .stall(stall), .trap_clr(trap_clr),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_en(ir_en),
        .pc_en(pc_en), .pc_sel(pc_sel), .reg_we(reg_we), .fault(fault),
        .fault_code(fault_code), .state(state), .instret(instret)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom % 2);
    endfunction

    function automatic int classify(input logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            default:    return K_ILL;
        endcase
    endfunction

    // One clock: drive inputs after the falling edge, then compare every output.
    task automatic step(input logic rdy, input logic stl, input logic clr, input logic [2:0] est,
                        input logic ereq, input logic ewe, input logic easel, input logic eir,
                        input logic epc, input logic epsel, input logic erwe, input logic [1:0] efc);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = rdy;
        stall = stl;
        trap_clr = clr;
        #1;
        chk("state", state, est);
        chk("mem_req", mem_req, ereq);
        chk("mem_we", mem_we, ewe);
        chk("addr_sel", addr_sel, easel);
        chk("ir_en", ir_en, eir);
        chk("pc_en", pc_en, epc);
        chk("pc_sel", pc_sel, epsel);
        chk("reg_we", reg_we, erwe);
        chk("fault", fault, est == 3'd7);
        chk("fault_code", fault_code, efc);
`ifdef RETIRE_CNT_EN
        chk("instret", instret, m_instret);
`else
        chk("instret", instret, 32'h0);
`endif
        if (epc) m_instret = m_instret + 32'd1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            mem_ready = rb();
            stall = rb();
            trap_clr = rb();
            #1;
            chk("rst_state", state, 3'd0);
            chk("rst_enables", {mem_req, mem_we, addr_sel, ir_en, pc_en, pc_sel, reg_we, fault}, 8'h0);
            chk("rst_fault_code", fault_code, 2'b00);
            chk("rst_instret", instret, 32'h0);
        end
        m_instret = 32'h0;
    endtask

    task automatic trap_phase(input logic [1:0] code, input int wait_n);
        for (int i = 0; i < wait_n; i++)
            step(rb(), rb(), 1'b0, 3'd7, 0, 0, 0, 0, 0, 0, 0, code);
        step(rb(), rb(), 1'b1, 3'd7, 0, 0, 0, 0, 0, 0, 0, code);
    endtask

    // Expected phase sequence of one instruction; fwait/mwait >= TO means the memory never answers.
    task automatic run_instr(input logic [6:0] op, input logic bt, input int fwait, input int mwait,
                             input int sd, input int se, input int sw, input int tclr_wait,
                             input int abort_mem);
        int k;
        logic st;
        k = classify(op);
        st = (k == K_STORE);
        opcode = op;
        branch_taken = bt;
        for (int w = 0; ; w++) begin
            if (w == fwait) begin
                step(1'b1, rb(), 1'b0, 3'd0, 1, 0, 0, 1, 0, 0, 0, 2'b00);
                break;
            end
            step(1'b0, rb(), 1'b0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 2'b00);
            if (w == int'(TO) - 1) begin
                trap_phase(2'b10, tclr_wait);
                return;
            end
        end
        for (int i = 0; i < sd; i++) step(rb(), 1'b1, 1'b0, 3'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        step(rb(), 1'b0, 1'b0, 3'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        if (k == K_ILL) begin
            trap_phase(2'b01, tclr_wait);
            return;
        end
        for (int i = 0; i < se; i++) step(rb(), 1'b1, 1'b0, 3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        if (k == K_BR) begin
            step(rb(), 1'b0, 1'b0, 3'd2, 0, 0, 0, 0, 1, bt, 0, 2'b00);
            return;
        end
        step(rb(), 1'b0, 1'b0, 3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        if (k == K_LOAD || k == K_STORE) begin
            for (int w = 0; ; w++) begin
                if (w == abort_mem) return;
                if (w == mwait) begin
                    step(1'b1, rb(), 1'b0, 3'd3, 1, st, 1, 0, st, 0, 0, 2'b00);
                    if (st) return;
                    break;
                end
                step(1'b0, rb(), 1'b0, 3'd3, 1, st, 1, 0, 0, 0, 0, 2'b00);
                if (w == int'(TO) - 1) begin
                    trap_phase(2'b11, tclr_wait);
                    return;
                end
            end
        end
        for (int i = 0; i < sw; i++) step(rb(), 1'b1, 1'b0, 3'd4, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        step(rb(), 1'b0, 1'b0, 3'd4, 0, 0, 0, 0, 1, (k == K_JAL || k == K_JALR), 1, 2'b00);
    endtask

    function automatic int pick_wait();
        return ($urandom % 6 == 0) ? int'(TO) + 1 : int'($urandom_range(0, TO - 1));
    endfunction

    logic [6:0] legal [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    initial begin
        logic [6:0] op;
        rst_n = 1'b0;
        opcode = 7'h0;
        branch_taken = 1'b0;
        mem_ready = 1'b0;
        stall = 1'b0;
        trap_clr = 1'b0;
        do_reset(3);

        run_instr(7'b0110011, 1'b0, 0, 0, 0, 0, 0, 0, -1);       // ADD, zero wait
        run_instr(7'b0000011, 1'b0, 0, 3, 0, 0, 0, 0, -1);       // LW, 3 wait cycles
        run_instr(7'b1100011, 1'b1, 0, 0, 0, 0, 0, 0, -1);       // BEQ taken
        run_instr(7'b1111111, 1'b0, 0, 0, 0, 0, 0, 2, -1);       // illegal opcode
        run_instr(7'b0110011, 1'b0, TO + 1, 0, 0, 0, 0, 1, -1);  // fetch timeout
        run_instr(7'b0110011, 1'b0, TO - 1, 0, 0, 0, 0, 0, -1);  // ready on last wait cycle
        run_instr(7'b0100011, 1'b0, 0, 0, 0, 3, 0, 0, -1);       // SW stalled in EXECUTE
        run_instr(7'b0100011, 1'b0, 1, TO + 1, 0, 0, 0, 0, -1);  // data timeout
        run_instr(7'b1101111, 1'b0, 0, 0, 1, 0, 2, 0, -1);       // JAL with stalls

        for (int n = 0; n < 300; n++) begin
            if ($urandom % 8 == 0) begin
                op = 7'($urandom);
                while (classify(op) != K_ILL) op = 7'($urandom);
            end else begin
                op = legal[$urandom % 9];
            end
            run_instr(op, rb(), pick_wait(), pick_wait(), int'($urandom % 3), int'($urandom % 3),
                      int'($urandom % 3), int'($urandom % 3), -1);
        end

        run_instr(7'b0000011, 1'b0, 0, 3, 0, 0, 0, 0, 2);        // reset while data request pending
        do_reset(1);
        run_instr(7'b0110011, 1'b0, 0, 0, 0, 0, 0, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
